// File: rtl/lz77_encoder.sv
// Streaming LZ77 encoder for hex-digit strings: captures symbols up to a '$'
// terminator, then emits (offset, match_len, char_nxt) tokens from a 9/8 window.
module lz77_encoder #(
    parameter int unsigned MAX_LEN = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] chardata,
    output logic       valid,
    output logic       encode,
    output logic       finish,
    output logic [3:0] offset,
    output logic [2:0] match_len,
    output logic [7:0] char_nxt
);

    localparam int unsigned AW   = $clog2(MAX_LEN);
    localparam int unsigned PW   = $clog2(MAX_LEN + 1);
    localparam int unsigned IW   = PW + 1;
    localparam int unsigned NOFF = 9;
    localparam int unsigned LA   = 7;
    localparam int unsigned WIN  = NOFF + LA + 1;
    localparam logic [7:0]  TERM = 8'h24;

    typedef enum logic [2:0] {
        RECV,
        CALC,
        EMIT,
        GAP,
        DONE
    } state_t;

    state_t        state, state_d;
    logic [3:0]    mem [MAX_LEN];
    logic [PW-1:0] wp, wp_d;
    logic [PW-1:0] end_ptr, end_ptr_d;
    logic [PW-1:0] cur, cur_d;
    logic          we;

    logic          valid_d, encode_d, finish_d;
    logic [3:0]    offset_d;
    logic [2:0]    match_len_d;
    logic [7:0]    char_nxt_d;

    logic [3:0]     win [WIN];
    logic [WIN-1:0] win_ok;
    logic [3:0]     best_off;
    logic [2:0]     best_len;
    logic [7:0]     next_chr;

    // Symbol window around the cursor: entries 0..8 are history, 9..16 look-ahead.
    always_comb begin
        logic [IW-1:0] pj;
        logic [IW-1:0] idx;
        win_ok = '0;
        for (int j = 0; j < int'(WIN); j++) begin
            pj        = IW'(cur) + IW'(j);
            idx       = pj - IW'(NOFF);
            win_ok[j] = (pj >= IW'(NOFF)) && (idx < IW'(end_ptr));
            win[j]    = win_ok[j] ? mem[AW'(idx)] : 4'h0;
        end
    end

    // Longest match over all offsets; strict '>' keeps the smallest offset on ties.
    always_comb begin
        logic [2:0] len;
        logic       run;
        best_len = '0;
        best_off = '0;
        next_chr = TERM;
        for (int o = 0; o < int'(NOFF); o++) begin
            len = '0;
            run = 1'b1;
            for (int k = 0; k < int'(LA); k++) begin
                if (run && win_ok[int'(NOFF) + k] &&
                    (win[int'(NOFF) - 1 - o + k] == win[int'(NOFF) + k])) begin
                    len = len + 3'd1;
                end else begin
                    run = 1'b0;
                end
            end
            if ((IW'(cur) > IW'(o)) && (len > best_len)) begin
                best_len = len;
                best_off = 4'(o);
            end
        end
        for (int k = 0; k <= int'(LA); k++) begin
            if (3'(k) == best_len) begin
                next_chr = win_ok[int'(NOFF) + k] ? {4'h0, win[int'(NOFF) + k]} : TERM;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        wp_d        = wp;
        end_ptr_d   = end_ptr;
        cur_d       = cur;
        we          = 1'b0;
        valid_d     = 1'b0;
        encode_d    = encode;
        finish_d    = finish;
        offset_d    = offset;
        match_len_d = match_len;
        char_nxt_d  = char_nxt;
        case (state)
            RECV: begin
                encode_d = 1'b1;
                if (chardata == TERM) begin
                    end_ptr_d = wp;
                    state_d   = CALC;
                end else if (wp < PW'(MAX_LEN)) begin
                    we   = 1'b1;
                    wp_d = wp + PW'(1);
                end
            end
            CALC: begin
                offset_d    = best_off;
                match_len_d = best_len;
                char_nxt_d  = next_chr;
                cur_d       = cur + PW'(best_len) + PW'(1);
                valid_d     = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (char_nxt == TERM) begin
                    encode_d = 1'b0;
                    finish_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = CALC;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RECV;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RECV;
            wp        <= '0;
            end_ptr   <= '0;
            cur       <= '0;
            valid     <= 1'b0;
            encode    <= 1'b0;
            finish    <= 1'b0;
            offset    <= '0;
            match_len <= '0;
            char_nxt  <= '0;
        end else begin
            state     <= state_d;
            wp        <= wp_d;
            end_ptr   <= end_ptr_d;
            cur       <= cur_d;
            valid     <= valid_d;
            encode    <= encode_d;
            finish    <= finish_d;
            offset    <= offset_d;
            match_len <= match_len_d;
            char_nxt  <= char_nxt_d;
        end
    end

    // Symbol store; contents need no reset since wp/end bound every read.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[AW'(wp)] <= chardata[3:0];
        end
    end

endmodule

// File: tb/tb_lz77_encoder.sv
// Directed and random-string bench for lz77_encoder with a reference token model.
module tb_lz77_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       valid;
    logic       encode;
    logic       finish;
    logic [3:0] offset;
    logic [2:0] match_len;
    logic [7:0] char_nxt;

    lz77_encoder #(.MAX_LEN(2048)) dut (
        .clk       (clk),
        .reset     (reset),
        .chardata  (chardata),
        .valid     (valid),
        .encode    (encode),
        .finish    (finish),
        .offset    (offset),
        .match_len (match_len),
        .char_nxt  (char_nxt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sym_q[$];
    int exp_off[$];
    int exp_len[$];
    int exp_chr[$];

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic exp_tok(input int o, input int l, input int c);
        exp_off.push_back(o);
        exp_len.push_back(l);
        exp_chr.push_back(c);
    endtask

    task automatic load_str(input string s);
        sym_q.delete();
        exp_off.delete();
        exp_len.delete();
        exp_chr.delete();
        for (int i = 0; i < s.len(); i++) sym_q.push_back(int'(s[i]) - 48);
    endtask

    // Reference encoder working directly on the symbol list.
    task automatic build_model();
        int p, n, bl, bo, l, s, c;
        exp_off.delete();
        exp_len.delete();
        exp_chr.delete();
        n = sym_q.size();
        p = 0;
        forever begin
            bl = 0;
            bo = 0;
            for (int o = 0; o < 9; o++) begin
                s = p - 1 - o;
                if (s >= 0) begin
                    l = 0;
                    while (l < 7 && p + l < n && sym_q[s + l] == sym_q[p + l]) l++;
                    if (l > bl) begin
                        bl = l;
                        bo = o;
                    end
                end
            end
            c = (p + bl == n) ? 36 : sym_q[p + bl];
            exp_tok(bo, bl, c);
            if (c == 36) break;
            p = p + bl + 1;
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset    = 1'b1;
        chardata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check({name, " rst valid"}, 32'(valid), 0);
        check({name, " rst encode"}, 32'(encode), 0);
        check({name, " rst finish"}, 32'(finish), 0);
        check({name, " rst token"}, {17'h0, offset, match_len, char_nxt}, 0);
        reset = 1'b0;
    endtask

    task automatic feed(input string name);
        int early_valid;
        early_valid = 0;
        for (int i = 0; i < sym_q.size(); i++) begin
            chardata = 8'(sym_q[i]);
            @(negedge clk);
            if (valid) early_valid++;
            if (i == 0) check({name, " encode recv"}, 32'(encode), 1);
        end
        check({name, " valid during recv"}, 32'(early_valid), 0);
    endtask

    // Sends the terminator then checks tokens; stops early after max_tok tokens if > 0.
    task automatic collect(input string name, input int max_tok);
        int cyc, tok, last, budget;
        bit done, aborted;
        chardata = 8'h24;
        cyc      = 0;
        tok      = 0;
        last     = -100;
        done     = 1'b0;
        aborted  = 1'b0;
        budget   = 3 * exp_off.size() + 20;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            chardata = 8'h00;
            if (finish) begin
                check({name, " valid with finish"}, 32'(valid), 0);
                check({name, " finish latency"}, 32'(cyc), last + 1);
                check({name, " encode at finish"}, 32'(encode), 0);
                done = 1'b1;
            end else if (valid) begin
                if (tok == 0) check({name, " first latency"}, 32'(cyc), 2);
                else check($sformatf("%s spacing tok%0d", name, tok), 32'(cyc - last >= 3), 1);
                check($sformatf("%s encode tok%0d", name, tok), 32'(encode), 1);
                if (tok < exp_off.size()) begin
                    check($sformatf("%s offset tok%0d", name, tok), 32'(offset), exp_off[tok]);
                    check($sformatf("%s len tok%0d", name, tok), 32'(match_len), exp_len[tok]);
                    check($sformatf("%s char tok%0d", name, tok), 32'(char_nxt), exp_chr[tok]);
                end else begin
                    check({name, " extra token"}, 32'(tok), exp_off.size() - 1);
                end
                last = cyc;
                tok++;
                if (max_tok > 0 && tok == max_tok) begin
                    done    = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        check({name, " completed in budget"}, 32'(done), 1);
        if (!aborted) check({name, " token count"}, 32'(tok), exp_off.size());
    endtask

    task automatic rand_string(input int n);
        sym_q.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) sym_q.push_back(int'($urandom_range(0, 15)));
            else sym_q.push_back(int'($urandom_range(0, 2)));
        end
        build_model();
    endtask

    initial begin
        reset    = 1'b1;
        chardata = 8'h00;
        do_reset("init");

        load_str("0000");
        exp_tok(0, 0, 0);
        exp_tok(0, 3, 36);
        feed("s0000");
        collect("s0000", 0);
        repeat (3) @(negedge clk);
        check("s0000 finish held", 32'(finish), 1);
        check("s0000 no valid in done", 32'(valid), 0);
        do_reset("r1");

        load_str("0120");
        exp_tok(0, 0, 0);
        exp_tok(0, 0, 1);
        exp_tok(0, 0, 2);
        exp_tok(2, 1, 36);
        feed("s0120");
        collect("s0120", 0);
        do_reset("r2");

        load_str("0000000000");
        exp_tok(0, 0, 0);
        exp_tok(0, 7, 0);
        exp_tok(0, 1, 36);
        feed("s10z");
        collect("s10z", 0);
        do_reset("r3");

        load_str("0010");
        exp_tok(0, 0, 0);
        exp_tok(0, 1, 1);
        exp_tok(1, 1, 36);
        feed("s0010");
        collect("s0010", 0);
        do_reset("r4");

        load_str("0001");
        exp_tok(0, 0, 0);
        exp_tok(0, 2, 1);
        exp_tok(0, 0, 36);
        feed("s0001");
        collect("s0001", 0);
        do_reset("r5");

        rand_string(2048);
        feed("rand2048");
        collect("rand2048", 0);
        do_reset("r6");

        rand_string(200);
        feed("abort");
        collect("abort", 5);
        do_reset("mid_abort");

        rand_string(300);
        feed("after_abort");
        collect("after_abort", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
